// File: rtl/ascon_pkg.sv
// Shared types and register-map constants for the ASCON scheduler.
package ascon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    ACK    = 2'd2,
    RUN    = 2'd3
  } sched_state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DATALEN = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_ABORT  = 3;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  function automatic logic [31:0] status_word(input logic busy, input logic done);
    logic [31:0] w;
    w = '0;
    w[STATUS_BUSY] = busy;
    w[STATUS_DONE] = done;
    return w;
  endfunction

endpackage

// File: rtl/ascon_mem_mux.sv
// Scratch-memory port select: the engine owns the port while it runs, Wishbone otherwise.
module ascon_mem_mux #(
  parameter int MEM_AW = 5
) (
  input  logic              sel_eng,
  input  logic              wb_we_n,
  input  logic [MEM_AW-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              eng_we_n,
  input  logic [MEM_AW-1:0] eng_addr,
  input  logic [31:0]       eng_data,
  output logic              mem_we_n,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_data
);

  assign mem_we_n = sel_eng ? eng_we_n : wb_we_n;
  assign mem_addr = sel_eng ? eng_addr : wb_addr;
  assign mem_data = sel_eng ? eng_data : wb_data;

endmodule

// File: rtl/ascon_sched.sv
// Wishbone scheduler for the ASCON core: register file, engine launch/completion,
// and arbitration of the scratch memory port between the bus and the engine.
module ascon_sched
  import ascon_pkg::*;
#(
  parameter int STALL_MAX = 255,
  parameter int MEM_AW    = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [5:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              busy_o,
  output logic [1:0]        mode_o,
  output logic [6:0]        datalen_o,
  input  logic              done_i,
  input  logic              eng_we_n_i,
  input  logic [MEM_AW-1:0] eng_addr_i,
  input  logic [31:0]       eng_datain_i,
  output logic              mem_we_n_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_datain_o,
  input  logic [31:0]       mem_dataout_i
);

  localparam int CW = $clog2(STALL_MAX + 1);

  sched_state_t      state, state_next;
  logic [CW-1:0]     stall_cnt;
  logic              reg_ack, err_q, done_q;
  logic [6:0]        datalen_q;
  logic [1:0]        reg_sel;
  logic [31:0]       reg_rdata;
  logic              req, reg_req, mem_req, reg_wr;
  logic              start_go, abort_go, status_clr, run_done;
  logic              wb_access, wb_mem_we_n;
  logic [MEM_AW-1:0] wb_mem_addr;
  logic [31:0]       wb_mem_data;

  // Valid/ready: a request is cyc&stb while no ack/err is being presented; the
  // master holds stb until it sees ack or err, so gating on them prevents re-issue.
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~err_q;
  assign reg_req    = req & wb_adr_i[5];
  assign mem_req    = req & ~wb_adr_i[5];
  assign reg_wr     = reg_req & wb_we_i;
  assign reg_sel    = wb_adr_i[1:0];
  assign start_go   = reg_wr & (reg_sel == REG_CTRL) & wb_dat_i[CTRL_START] & (state == IDLE);
  assign abort_go   = reg_wr & (reg_sel == REG_CTRL) & wb_dat_i[CTRL_ABORT] & (state == RUN);
  assign status_clr = reg_wr & (reg_sel == REG_STATUS) & wb_dat_i[STATUS_DONE];
  assign run_done   = (state == RUN) & done_i;

  assign busy_o   = (state == RUN);
  assign wb_ack_o = reg_ack | (state == ACK);
  assign wb_err_o = err_q;

  // Memory writes from the bus commit only in IDLE; reads present the address in IDLE and MEM_RD.
  assign wb_access   = ~RST & mem_req & ((state == IDLE) | (state == MEM_RD));
  assign wb_mem_we_n = ~(wb_access & (state == IDLE) & wb_we_i);
  assign wb_mem_addr = wb_access ? wb_adr_i[MEM_AW-1:0] : '0;
  assign wb_mem_data = wb_mem_we_n ? '0 : wb_dat_i;

  ascon_mem_mux #(.MEM_AW(MEM_AW)) u_mux (
    .sel_eng  (busy_o),
    .wb_we_n  (wb_mem_we_n),
    .wb_addr  (wb_mem_addr),
    .wb_data  (wb_mem_data),
    .eng_we_n (eng_we_n_i),
    .eng_addr (eng_addr_i),
    .eng_data (eng_datain_i),
    .mem_we_n (mem_we_n_o),
    .mem_addr (mem_addr_o),
    .mem_data (mem_datain_o)
  );

  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_go)     state_next = RUN;
        else if (mem_req) state_next = wb_we_i ? ACK : MEM_RD;
      end
      MEM_RD:  state_next = (wb_cyc_i & wb_stb_i) ? ACK : IDLE;
      ACK:     state_next = IDLE;
      RUN:     if (done_i || abort_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_CTRL:    reg_rdata[CTRL_MODE +: 2] = mode_o;
      REG_DATALEN: reg_rdata[6:0] = datalen_q;
      REG_STATUS:  reg_rdata = status_word(busy_o, done_q);
      REG_RSVD:    reg_rdata = '0;
      default:     reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      reg_ack   <= 1'b0;
      err_q     <= 1'b0;
      wb_dat_o  <= '0;
      mode_o    <= '0;
      datalen_o <= '0;
      datalen_q <= '0;
      done_q    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      reg_ack <= reg_req;
      err_q   <= 1'b0;
      if (reg_req && !wb_we_i)
        wb_dat_o <= reg_rdata;
      else if (state == MEM_RD && wb_cyc_i && wb_stb_i)
        wb_dat_o <= mem_dataout_i;
      if (start_go) begin
        mode_o    <= wb_dat_i[CTRL_MODE +: 2];
        datalen_o <= datalen_q;
      end
      if (reg_wr && reg_sel == REG_DATALEN && state != RUN)
        datalen_q <= wb_dat_i[6:0];
      if (run_done)                     done_q <= 1'b1;
      else if (start_go || status_clr)  done_q <= 1'b0;
      // A bus memory access held off by the engine times out after STALL_MAX cycles.
      if (state != RUN || done_i || !mem_req) begin
        stall_cnt <= '0;
      end else if (stall_cnt == CW'(STALL_MAX - 1)) begin
        stall_cnt <= '0;
        err_q     <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ascon_sched.sv
// Directed bench for ascon_sched with a behavioural 32x32 synchronous scratch memory.
module tb_ascon_sched;

  localparam logic [5:0] A_CTRL = 6'h20;
  localparam logic [5:0] A_DLEN = 6'h21;
  localparam logic [5:0] A_STAT = 6'h22;
  localparam logic [5:0] A_RSVD = 6'h23;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [5:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, busy_o;
  logic [1:0]  mode_o;
  logic [6:0]  datalen_o;
  logic        done_i = 1'b0;
  logic        eng_we_n_i = 1'b1;
  logic [4:0]  eng_addr_i = '0;
  logic [31:0] eng_datain_i = '0;
  logic        mem_we_n_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_datain_o;
  logic [31:0] mem_dataout_i;

  logic [31:0] mem [32];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  ascon_sched #(.STALL_MAX(8), .MEM_AW(5)) dut (
    .clk           (clk),
    .RST           (RST),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_we_i       (wb_we_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .busy_o        (busy_o),
    .mode_o        (mode_o),
    .datalen_o     (datalen_o),
    .done_i        (done_i),
    .eng_we_n_i    (eng_we_n_i),
    .eng_addr_i    (eng_addr_i),
    .eng_datain_i  (eng_datain_i),
    .mem_we_n_o    (mem_we_n_o),
    .mem_addr_o    (mem_addr_o),
    .mem_datain_o  (mem_datain_o),
    .mem_dataout_i (mem_dataout_i)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(posedge clk) begin
    if (!mem_we_n_o) mem[mem_addr_o] <= mem_datain_o;
    mem_dataout_i <= mem[mem_addr_o];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one Wishbone access, bounded by budget cycles, followed by an idle cycle
  task automatic wb_cycle(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                          input int budget, output int lat, output logic [31:0] rdat,
                          output logic got_ack, output logic got_err);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
    while (lat < budget && !got_ack && !got_err) begin
      tick();
      lat++;
      got_ack = wb_ack_o;
      got_err = wb_err_o;
      rdat    = wb_dat_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    tick();
  endtask

  task automatic wb_write_chk(input string tag, input logic [5:0] adr, input logic [31:0] dat);
    int lat; logic [31:0] rdat; logic ack, err;
    wb_cycle(1'b1, adr, dat, 20, lat, rdat, ack, err);
    check_val({tag, " ack"}, 32'(ack), 32'd1);
    check_val({tag, " latency"}, 32'(lat), 32'd1);
  endtask

  task automatic wb_read_chk(input string tag, input logic [5:0] adr, input logic [31:0] exp,
                             input int exp_lat);
    int lat; logic [31:0] rdat; logic ack, err;
    exp_q.push_back(exp);
    wb_cycle(1'b0, adr, 32'd0, 20, lat, rdat, ack, err);
    check_val({tag, " ack"}, 32'(ack), 32'd1);
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " data"}, rdat, exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " busy"}, 32'(busy_o), 32'd0);
    check_val({tag, " mode"}, 32'(mode_o), 32'd0);
    check_val({tag, " datalen"}, 32'(datalen_o), 32'd0);
    check_val({tag, " ack"}, 32'(wb_ack_o), 32'd0);
    check_val({tag, " err"}, 32'(wb_err_o), 32'd0);
    check_val({tag, " dat_o"}, wb_dat_o, 32'd0);
    check_val({tag, " mem_we_n"}, 32'(mem_we_n_o), 32'd1);
    check_val({tag, " mem_addr"}, 32'(mem_addr_o), 32'd0);
    check_val({tag, " mem_data"}, mem_datain_o, 32'd0);
  endtask

  initial begin
    int lat; logic [31:0] rdat; logic ack, err;

    RST = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    RST = 1'b0;
    tick();

    wb_write_chk("mem5_wr", 6'd5, 32'hDEADBEEF);
    wb_read_chk("mem5_rd", 6'd5, 32'hDEADBEEF, 2);

    wb_write_chk("dlen_wr", A_DLEN, 32'd40);
    check_val("busy_before_start", 32'(busy_o), 32'd0);
    wb_write_chk("start", A_CTRL, 32'h3);
    check_val("start busy", 32'(busy_o), 32'd1);
    check_val("start mode", 32'(mode_o), 32'd1);
    check_val("start datalen", 32'(datalen_o), 32'd40);

    eng_we_n_i = 1'b0; eng_addr_i = 5'd7; eng_datain_i = 32'h12345678;
    #1;
    check_val("eng we_n", 32'(mem_we_n_o), 32'd0);
    check_val("eng addr", 32'(mem_addr_o), 32'd7);
    check_val("eng data", mem_datain_o, 32'h12345678);
    tick();
    eng_we_n_i = 1'b1; eng_addr_i = '0; eng_datain_i = '0;

    wb_read_chk("status_run", A_STAT, 32'h1, 1);
    wb_write_chk("dlen_wr_run", A_DLEN, 32'd99);

    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_val("done busy", 32'(busy_o), 32'd0);
    wb_read_chk("status_done", A_STAT, 32'h2, 1);
    wb_write_chk("status_w1c", A_STAT, 32'h2);
    wb_read_chk("status_cleared", A_STAT, 32'h0, 1);
    wb_read_chk("eng_mem7", 6'd7, 32'h12345678, 2);
    wb_read_chk("dlen_kept", A_DLEN, 32'd40, 1);

    // bus read stalled by the engine until timeout
    wb_write_chk("start2", A_CTRL, 32'h1);
    check_val("start2 busy", 32'(busy_o), 32'd1);
    wb_cycle(1'b0, 6'd5, 32'd0, 20, lat, rdat, ack, err);
    check_val("stall err", 32'(err), 32'd1);
    check_val("stall no ack", 32'(ack), 32'd0);
    check_val("stall latency", 32'(lat), 32'd8);
    check_val("stall busy kept", 32'(busy_o), 32'd1);

    // bus read stalled, then served once the engine completes
    fork
      wb_cycle(1'b0, 6'd5, 32'd0, 20, lat, rdat, ack, err);
      begin
        repeat (3) tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
      end
    join
    check_val("pend ack", 32'(ack), 32'd1);
    check_val("pend err", 32'(err), 32'd0);
    check_val("pend latency", 32'(lat), 32'd6);
    check_val("pend data", rdat, 32'hDEADBEEF);
    wb_read_chk("status_done2", A_STAT, 32'h2, 1);

    wb_write_chk("start3", A_CTRL, 32'h5);
    check_val("start3 mode", 32'(mode_o), 32'd2);
    wb_read_chk("status_run3", A_STAT, 32'h1, 1);
    wb_write_chk("abort", A_CTRL, 32'h8);
    check_val("abort busy", 32'(busy_o), 32'd0);
    wb_read_chk("status_abort", A_STAT, 32'h0, 1);

    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    wb_read_chk("status_done_idle", A_STAT, 32'h0, 1);

    wb_write_chk("rsvd_wr", A_RSVD, 32'hFFFFFFFF);
    wb_read_chk("rsvd_rd", A_RSVD, 32'h0, 1);

    // master abandons a memory read after one cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 6'd5;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_adr_i = '0;
    tick();
    check_val("drop ack1", 32'(wb_ack_o), 32'd0);
    tick();
    check_val("drop ack2", 32'(wb_ack_o), 32'd0);
    check_val("drop err", 32'(wb_err_o), 32'd0);
    wb_read_chk("mem5_after_drop", 6'd5, 32'hDEADBEEF, 2);

    wb_write_chk("start4", A_CTRL, 32'h7);
    check_val("start4 busy", 32'(busy_o), 32'd1);
    check_val("start4 mode", 32'(mode_o), 32'd3);
    wb_read_chk("dlen_run4", A_DLEN, 32'd40, 1);
    RST = 1'b1;
    tick();
    check_reset_outputs("rst_mid_run");
    RST = 1'b0;
    tick();
    wb_read_chk("dlen_after_rst", A_DLEN, 32'd0, 1);
    wb_read_chk("status_after_rst", A_STAT, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
